// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: FSM state encoding and accumulator sizing.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_HOLD  = 2'd3
  } mix_state_e;

  // Width that holds the sum of num_voices signed words without overflow.
  function automatic int acc_bits(input int word_bits, input int num_voices);
    return word_bits + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/voice_mixer_sat_trunc.sv
// Combinational saturate-then-truncate: clamps a signed IN_BITS value to the signed
// MID_BITS range, then drops the MID_BITS-OUT_BITS least significant bits.
module sat_trunc #(
  parameter int IN_BITS  = 21,
  parameter int MID_BITS = 18,
  parameter int OUT_BITS = 16
) (
  input  logic [IN_BITS-1:0]  in_i,
  output logic [OUT_BITS-1:0] out_o
);

  logic [IN_BITS-MID_BITS:0] top_s;
  logic [MID_BITS-1:0]       mid_s;

  // In range when every bit above the MID_BITS sign bit matches that sign bit.
  always_comb begin
    top_s = in_i[IN_BITS-1:MID_BITS-1];
    if ((top_s == '0) || (top_s == '1)) begin
      mid_s = in_i[MID_BITS-1:0];
    end else if (in_i[IN_BITS-1]) begin
      mid_s = {1'b1, {(MID_BITS-1){1'b0}}};
    end else begin
      mid_s = {1'b0, {(MID_BITS-1){1'b1}}};
    end
    out_o = OUT_BITS'(mid_s >> (MID_BITS - OUT_BITS));
  end

endmodule

// File: rtl/voice_mixer.sv
// Serial voice mixer: snapshots all voice words on a sample tick, sums the active
// ones one per cycle, attenuates, saturates and offers the sample on valid/ready.
module voice_mixer #(
  parameter int NUM_VOICES    = 8,
  parameter int NUM_BITS_WORD = 18,
  parameter int OUT_BITS      = 16,
  parameter int GAIN_SHIFT    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_tick,
  input  logic [NUM_VOICES*NUM_BITS_WORD-1:0] voice_words,
  input  logic [NUM_VOICES-1:0]               voice_active,
  output logic [OUT_BITS-1:0]                 mix_out,
  output logic                                mix_valid,
  input  logic                                mix_ready,
  output logic                                busy,
  output logic                                overrun
);

  import voice_mixer_pkg::*;

  localparam int ACC_BITS = acc_bits(NUM_BITS_WORD, NUM_VOICES);
  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

  mix_state_e                          state_q;
  logic [NUM_VOICES*NUM_BITS_WORD-1:0] words_q;
  logic [NUM_VOICES-1:0]               active_q;
  logic [ACC_BITS-1:0]                 acc_q;
  logic [ACC_BITS-1:0]                 acc_d;
  logic [IDX_BITS-1:0]                 idx_q;
  logic [OUT_BITS-1:0]                 mix_out_q;
  logic                                mix_valid_q;
  logic                                busy_q;
  logic                                overrun_q;

  logic [NUM_BITS_WORD-1:0]            cur_word_s;
  logic signed [ACC_BITS-1:0]          scaled_s;
  logic [OUT_BITS-1:0]                 sat_s;
  logic                                start_s;
  logic                                drop_s;

  // Next accumulator value and frame start/drop decisions for the current cycle.
  always_comb begin
    cur_word_s = words_q[idx_q*NUM_BITS_WORD +: NUM_BITS_WORD];
    if (active_q[idx_q]) begin
      acc_d = acc_q + {{(ACC_BITS-NUM_BITS_WORD){cur_word_s[NUM_BITS_WORD-1]}}, cur_word_s};
    end else begin
      acc_d = acc_q;
    end
    scaled_s = $signed(acc_q) >>> GAIN_SHIFT;
    start_s  = sample_tick && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && mix_ready));
    drop_s   = sample_tick && (state_q != ST_IDLE) && !start_s;
  end

  sat_trunc #(
    .IN_BITS  (ACC_BITS),
    .MID_BITS (NUM_BITS_WORD),
    .OUT_BITS (OUT_BITS)
  ) u_sat_trunc (
    .in_i  (scaled_s),
    .out_o (sat_s)
  );

  // Frame FSM with snapshot, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      words_q     <= '0;
      active_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= drop_s;
      if (start_s) begin
        words_q     <= voice_words;
        active_q    <= voice_active;
        acc_q       <= '0;
        idx_q       <= '0;
        state_q     <= ST_ACCUM;
        busy_q      <= 1'b1;
        mix_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q      <= 1'b0;
            mix_valid_q <= 1'b0;
          end
          ST_ACCUM: begin
            acc_q <= acc_d;
            idx_q <= idx_q + IDX_BITS'(1);
            if (idx_q == LAST_IDX) begin
              state_q <= ST_SCALE;
            end
          end
          ST_SCALE: begin
            mix_out_q   <= sat_s;
            mix_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
          ST_HOLD: begin
            if (mix_ready) begin
              mix_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            mix_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
